// File: rtl/seq_comparer.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle, MSB chunk first.
// Optional macro SEQ_COMPARER_EARLY_EXIT_EN: finish at the first differing chunk instead of after all NCH chunks.
module seq_comparer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [2:0]       f
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_LT = 3'b010;
    localparam logic [2:0] RES_EQ = 3'b001;

    if ((WIDTH % CHUNK) != 0 || NCH < 1) begin : g_bad_param
        $error("seq_comparer: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IDXW-1:0]   r_idx;
    logic [IDXW-1:0]   w_idx_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  w_a_next;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  w_b_next;
    logic              r_sgn;
    logic              w_sgn_next;
    logic              r_decided;
    logic              w_decided_next;
    logic [2:0]        r_res;
    logic [2:0]        w_res_next;
    logic [2:0]        r_f;
    logic [2:0]        w_f_next;
    logic              r_done;
    logic              w_done_next;

    logic [CHUNK-1:0]  w_chunk_a [NCH];
    logic [CHUNK-1:0]  w_chunk_b [NCH];
    logic [CHUNK-1:0]  w_sign_mask;
    logic [CHUNK-1:0]  w_cur_a;
    logic [CHUNK-1:0]  w_cur_b;
    logic              w_gt;
    logic              w_lt;
    logic              w_last;
    logic              w_finish;
    logic [2:0]        w_step_res;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_sign_mask = CHUNK'(r_sgn) << (CHUNK - 1);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
        if (gi == NCH - 1) begin : g_top
            assign w_chunk_a[gi] = r_a[gi*CHUNK +: CHUNK] ^ w_sign_mask;
            assign w_chunk_b[gi] = r_b[gi*CHUNK +: CHUNK] ^ w_sign_mask;
        end else begin : g_low
            assign w_chunk_a[gi] = r_a[gi*CHUNK +: CHUNK];
            assign w_chunk_b[gi] = r_b[gi*CHUNK +: CHUNK];
        end
    end

    assign w_cur_a = w_chunk_a[r_idx];
    assign w_cur_b = w_chunk_b[r_idx];
    assign w_gt    = (w_cur_a > w_cur_b);
    assign w_lt    = (w_cur_a < w_cur_b);
    assign w_last  = (r_idx == '0);

    // Once a chunk has differed, lower chunks can no longer change the verdict.
    always_comb begin
        w_step_res = RES_EQ;
        if (r_decided) begin
            w_step_res = r_res;
        end else if (w_gt) begin
            w_step_res = RES_GT;
        end else if (w_lt) begin
            w_step_res = RES_LT;
        end
    end

`ifdef SEQ_COMPARER_EARLY_EXIT_EN
    assign w_finish = w_last || w_gt || w_lt;
`else
    assign w_finish = w_last;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_a_next       = r_a;
        w_b_next       = r_b;
        w_sgn_next     = r_sgn;
        w_decided_next = r_decided;
        w_res_next     = r_res;
        w_f_next       = r_f;
        w_done_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_next       = a;
                    w_b_next       = b;
                    w_sgn_next     = sgn;
                    w_idx_next     = IDXW'(NCH - 1);
                    w_decided_next = 1'b0;
                    w_res_next     = RES_EQ;
                    w_state_next   = S_RUN;
                end
            end
            S_RUN: begin
                w_decided_next = r_decided || w_gt || w_lt;
                w_res_next     = w_step_res;
                if (w_finish) begin
                    w_state_next = S_IDLE;
                    w_f_next     = w_step_res;
                    w_done_next  = 1'b1;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next   = r_idx - IDXW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_sgn     <= 1'b0;
            r_decided <= 1'b0;
            r_res     <= 3'b000;
            r_f       <= 3'b000;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_a       <= w_a_next;
            r_b       <= w_b_next;
            r_sgn     <= w_sgn_next;
            r_decided <= w_decided_next;
            r_res     <= w_res_next;
            r_f       <= w_f_next;
            r_done    <= w_done_next;
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign f    = r_f;

endmodule
